// File: rtl/qmac_accum.sv
// qmac_accum: sequences operand pairs through an external serial sign-magnitude multiplier and
// accumulates saturated dot products. Optional product watchdog enabled by defining QMAC_TIMEOUT_EN.
module qmac_accum #(
    parameter int unsigned N       = 32,
    parameter int unsigned Q       = 15,
    parameter int unsigned GUARD   = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_last,
    output logic [N-1:0] o_mul_a,
    output logic [N-1:0] o_mul_b,
    output logic         o_mul_start,
    input  logic [N-1:0] i_mul_result,
    input  logic         i_mul_complete,
    input  logic         i_mul_overflow,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_overflow
);

    localparam int unsigned AW = N + GUARD;
    localparam logic signed [AW-1:0] ACC_MAX = {{(GUARD + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;

    // Q is carried only for documentation; products arrive already aligned.
    if (N < 2 || Q >= N || GUARD < 2 || TIMEOUT == 0) begin : g_unsupported_params
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ACCUM,
        S_OUT
`ifdef QMAC_TIMEOUT_EN
        , S_DRAIN
`endif
    } state_t;

    state_t                 state;
    logic                   last_q;
    logic                   ovf_q;
    logic [N-1:0]           prod_q;
    logic                   prod_ovf_q;
    logic signed [AW-1:0]   acc_q;

    logic signed [AW-1:0]   prod_mag;
    logic signed [AW-1:0]   prod_tc;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   acc_next;
    logic                   sat;
    logic                   ovf_next;
    logic [N-2:0]           res_mag;
    logic [N-1:0]           result_sm;

`ifdef QMAC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
`endif

    // Product to two's complement, saturating add, and sign-magnitude view of the new sum.
    always_comb begin
        prod_mag  = AW'(prod_q[N-2:0]);
        prod_tc   = prod_q[N-1] ? -prod_mag : prod_mag;
        sum       = acc_q + prod_tc;
        acc_next  = sum;
        sat       = 1'b0;
        if (sum > ACC_MAX) begin
            acc_next = ACC_MAX;
            sat      = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_next = ACC_MIN;
            sat      = 1'b1;
        end
        ovf_next  = ovf_q | sat | prod_ovf_q;
        res_mag   = (N - 1)'(acc_next[AW-1] ? -acc_next : acc_next);
        result_sm = {acc_next[AW-1], res_mag};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            prod_q      <= '0;
            prod_ovf_q  <= 1'b0;
            acc_q       <= '0;
            o_ready     <= 1'b1;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_mul_start <= 1'b0;
            o_valid     <= 1'b0;
            o_result    <= '0;
            o_overflow  <= 1'b0;
`ifdef QMAC_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        o_mul_a     <= i_a;
                        o_mul_b     <= i_b;
                        last_q      <= i_last;
                        o_ready     <= 1'b0;
                        o_mul_start <= 1'b1;
                        state       <= S_ISSUE;
`ifdef QMAC_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
`ifdef QMAC_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + CW'(1);
`endif
                    if (state == S_WAIT_BUSY && !i_mul_complete) begin
                        o_mul_start <= 1'b0;
                        state       <= S_WAIT_DONE;
                    end else if (state == S_WAIT_DONE && i_mul_complete) begin
                        prod_q     <= i_mul_result;
                        prod_ovf_q <= i_mul_overflow;
                        state      <= S_ACCUM;
                    end
`ifdef QMAC_TIMEOUT_EN
                    // Watchdog abort: discard the vector, report zero with overflow.
                    else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        o_mul_start <= 1'b0;
                        acc_q       <= '0;
                        ovf_q       <= 1'b1;
                        if (last_q) begin
                            o_valid    <= 1'b1;
                            o_result   <= '0;
                            o_overflow <= 1'b1;
                            state      <= S_OUT;
                        end else begin
                            o_ready <= 1'b1;
                            state   <= S_DRAIN;
                        end
                    end
`endif
                end
                S_ACCUM: begin
                    acc_q <= acc_next;
                    ovf_q <= ovf_next;
                    if (last_q) begin
                        o_result   <= result_sm;
                        o_overflow <= ovf_next;
                        o_valid    <= 1'b1;
                        state      <= S_OUT;
                    end else begin
                        o_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_valid    <= 1'b0;
                        o_overflow <= 1'b0;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        o_ready    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
`ifdef QMAC_TIMEOUT_EN
                S_DRAIN: begin
                    if (i_valid && i_last) begin
                        o_ready    <= 1'b0;
                        o_valid    <= 1'b1;
                        o_result   <= '0;
                        o_overflow <= 1'b1;
                        state      <= S_OUT;
                    end
                end
`endif
                default: begin
                    o_ready <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qmac_accum.sv
// tb_qmac_accum: randomized and directed checks of qmac_accum against a behavioural multiplier
// and an arithmetic dot-product reference (N=16, Q=8).
module tb_qmac_accum;

    localparam int unsigned N       = 16;
    localparam int unsigned Q       = 8;
    localparam int unsigned GUARD   = 4;
    localparam int unsigned TIMEOUT = 40;
    localparam longint      MAXM    = (longint'(1) << (N - 1)) - 1;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [N-1:0] i_a = '0;
    logic [N-1:0] i_b = '0;
    logic         i_last = 1'b0;
    logic [N-1:0] o_mul_a;
    logic [N-1:0] o_mul_b;
    logic         o_mul_start;
    logic [N-1:0] mul_result = '0;
    logic         mul_complete = 1'b1;
    logic         mul_overflow = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [N-1:0] o_result;
    logic         o_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    logic prev_valid = 1'b0;

    logic [N-1:0] va [0:7];
    logic [N-1:0] vb [0:7];

    qmac_accum #(.N(N), .Q(Q), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_a            (i_a),
        .i_b            (i_b),
        .i_last         (i_last),
        .o_mul_a        (o_mul_a),
        .o_mul_b        (o_mul_b),
        .o_mul_start    (o_mul_start),
        .i_mul_result   (mul_result),
        .i_mul_complete (mul_complete),
        .i_mul_overflow (mul_overflow),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_result       (o_result),
        .o_overflow     (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Sign-magnitude Q product: {overflow, sign, magnitude}.
    function automatic logic [N:0] mul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        logic   ov;
        p  = (longint'(a[N-2:0]) * longint'(b[N-2:0])) >>> Q;
        ov = (p > MAXM);
        if (ov) p = MAXM;
        return {ov, a[N-1] ^ b[N-1], (N - 1)'(p)};
    endfunction

    // Saturating dot product of va/vb; returns {overflow, sign-magnitude result}.
    function automatic logic [N:0] dot_ref(input int len);
        longint       acc;
        longint       p;
        logic         ov;
        logic [N:0]   r;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < len; i++) begin
            r  = mul_ref(va[i], vb[i]);
            ov = ov | r[N];
            p  = longint'(r[N-2:0]);
            if (r[N-1]) p = -p;
            acc = acc + p;
            if (acc > MAXM) begin
                acc = MAXM;
                ov  = 1'b1;
            end else if (acc < -MAXM) begin
                acc = -MAXM;
                ov  = 1'b1;
            end
        end
        return {ov, acc < 0, (N - 1)'(acc < 0 ? -acc : acc)};
    endfunction

    // Behavioural serial multiplier with random latency; mul_hang stalls it forever.
    logic mul_busy = 1'b0;
    logic mul_hang = 1'b0;
    int   mul_left = 0;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mul_busy     <= 1'b0;
            mul_complete <= 1'b1;
        end else if (!mul_busy) begin
            if (o_mul_start && mul_complete) begin
                mul_busy                   <= 1'b1;
                mul_complete               <= 1'b0;
                mul_left                   <= int'($urandom_range(1, 5));
                {mul_overflow, mul_result} <= mul_ref(o_mul_a, o_mul_b);
            end
        end else if (!mul_hang) begin
            if (mul_left <= 1) begin
                mul_busy     <= 1'b0;
                mul_complete <= 1'b1;
            end else begin
                mul_left <= mul_left - 1;
            end
        end
    end

    always @(posedge i_clk) begin
        prev_valid <= o_valid;
        if (o_valid && !prev_valid) n_pulses <= n_pulses + 1;
    end

    // Drives one vector from va/vb and collects its result; starts and ends on a falling edge.
    task automatic drive_vector(input int len, input int hold,
                                output logic [N-1:0] res, output logic ovf,
                                output bit stable, output bit released, output bit ok);
        int t;
        ok = 1'b1; stable = 1'b1; released = 1'b0; res = '0; ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            t = 0;
            while (!o_ready && t < 500) begin @(negedge i_clk); t++; end
            if (!o_ready) begin ok = 1'b0; return; end
            i_valid = 1'b1; i_a = va[i]; i_b = vb[i]; i_last = (i == len - 1);
            @(negedge i_clk);
            i_valid = 1'b0; i_last = 1'b0;
        end
        t = 0;
        while (!o_valid && t < 500) begin @(negedge i_clk); t++; end
        if (!o_valid) begin ok = 1'b0; return; end
        res = o_result;
        ovf = o_overflow;
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            if (!(o_valid && !o_ready && o_result === res && o_overflow === ovf)) stable = 1'b0;
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        released = (!o_valid && o_ready);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n  = 1'b1;
        mul_hang = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_reset();
        logic [3*N+3:0] got;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        got = {o_ready, o_mul_start, o_valid, o_overflow, o_mul_a, o_mul_b, o_result};
        n_checks++;
        if (got !== {1'b1, 3'b000, {(3 * N){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got, {1'b1, 3'b000, {(3 * N){1'b0}}});
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    // Directed vector: checks completion, result, overflow, hold stability and release.
    task automatic test_directed(input string name, input int len, input int hold,
                                 input logic [N-1:0] exp_res, input logic exp_ovf);
        logic [N-1:0] res;
        logic         ovf;
        bit           stable, released, ok;
        int           p0;
        p0 = n_pulses;
        drive_vector(len, hold, res, ovf, stable, released, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: no result within cycle budget, expected %h", name, exp_res);
            do_reset();
            return;
        end
        n_checks++;
        if (res !== exp_res) begin
            n_fail++;
            $display("FAIL %s_result: got %h expected %h", name, res, exp_res);
        end
        n_checks++;
        if (ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s_overflow: got %b expected %b", name, ovf, exp_ovf);
        end
        n_checks++;
        if (!stable || !released || (n_pulses - p0) != 1) begin
            n_fail++;
            $display("FAIL %s_handshake: stable %b released %b pulses %0d expected 1 1 1",
                     name, stable, released, n_pulses - p0);
        end
    endtask

    task automatic test_single();
        va[0] = 16'h0200; vb[0] = 16'h0180;
        test_directed("single", 1, 0, 16'h0300, 1'b0);
    endtask

    task automatic test_three();
        va[0] = 16'h0200; vb[0] = 16'h0180;
        va[1] = 16'h8100; vb[1] = 16'h0100;
        va[2] = 16'h0080; vb[2] = 16'h0080;
        test_directed("three", 3, 0, 16'h0240, 1'b0);
    endtask

    task automatic test_clamp();
        va[0] = 16'h7F00; vb[0] = 16'h0100;
        va[1] = 16'h7F00; vb[1] = 16'h0100;
        test_directed("clamp", 2, 0, 16'h7FFF, 1'b1);
        va[0] = 16'h0100; vb[0] = 16'h0100;
        test_directed("after_clamp", 1, 0, 16'h0100, 1'b0);
    endtask

    task automatic test_neg_zero_backpressure();
        va[0] = 16'h0100; vb[0] = 16'h0100;
        va[1] = 16'h8100; vb[1] = 16'h0100;
        test_directed("zero_hold", 2, 5, 16'h0000, 1'b0);
    endtask

    task automatic test_random();
        logic [N:0]   exp;
        logic [N-1:0] mask;
        int           len;
        for (int v = 0; v < 25; v++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0:       mask = 16'h00FF;
                    1:       mask = 16'h0FFF;
                    default: mask = 16'h7FFF;
                endcase
                va[i] = {1'($urandom), 15'($urandom)} & {1'b1, mask[N-2:0]};
                vb[i] = {1'($urandom), 15'($urandom)} & {1'b1, mask[N-2:0]};
            end
            exp = dot_ref(len);
            test_directed("random", len, int'($urandom_range(0, 3)), exp[N-1:0], exp[N]);
        end
    endtask

    task automatic test_reset_mid();
        logic [3*N+3:0] got;
        mul_hang = 1'b1;
        va[0] = 16'h0300; vb[0] = 16'h0100;
        i_valid = 1'b1; i_a = va[0]; i_b = vb[0]; i_last = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_last = 1'b0;
        repeat (6) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        got = {o_ready, o_mul_start, o_valid, o_overflow, o_mul_a, o_mul_b, o_result};
        n_checks++;
        if (got !== {1'b1, 3'b000, {(3 * N){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected %h", got, {1'b1, 3'b000, {(3 * N){1'b0}}});
        end
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        mul_hang = 1'b0;
        repeat (3) @(negedge i_clk);
        va[0] = 16'h0200; vb[0] = 16'h0180;
        va[1] = 16'h8100; vb[1] = 16'h0100;
        va[2] = 16'h0080; vb[2] = 16'h0080;
        test_directed("after_reset", 3, 1, 16'h0240, 1'b0);
    endtask

`ifdef QMAC_TIMEOUT_EN
    task automatic test_timeout();
        mul_hang = 1'b1;
        va[0] = 16'h0100; vb[0] = 16'h0100;
        va[1] = 16'h0200; vb[1] = 16'h0100;
        va[2] = 16'h0300; vb[2] = 16'h0100;
        test_directed("timeout_drain", 3, 2, 16'h0000, 1'b1);
        do_reset();
        mul_hang = 1'b1;
        test_directed("timeout_last", 1, 0, 16'h0000, 1'b1);
        do_reset();
    endtask
`else
    task automatic test_timeout();
        bit seen_valid;
        bit seen_ready;
        mul_hang = 1'b1;
        seen_valid = 1'b0;
        seen_ready = 1'b0;
        i_valid = 1'b1; i_a = 16'h0100; i_b = 16'h0100; i_last = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_last = 1'b0;
        repeat (100) begin
            @(negedge i_clk);
            if (o_valid) seen_valid = 1'b1;
            if (o_ready) seen_ready = 1'b1;
        end
        n_checks++;
        if (seen_valid || seen_ready) begin
            n_fail++;
            $display("FAIL hang_no_result: o_valid seen %b o_ready seen %b expected 0 0",
                     seen_valid, seen_ready);
        end
        do_reset();
    endtask
`endif

    initial begin
        repeat (2) @(negedge i_clk);
        test_reset();
        test_single();
        test_three();
        test_clamp();
        test_neg_zero_backpressure();
        test_random();
        test_reset_mid();
        test_timeout();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
